// File: rtl/dip_debounce.sv
// DIP switch conditioner: 2-flop synchroniser, per-bit consecutive-stability filter,
// registered levels and one-cycle rise/fall/changed strobes.
module dip_debounce_bit #(
    parameter int STABLE_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_res,
    input  logic i_sync,
    output logic o_level,
    output logic o_take
);
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          w_diff;
    logic          w_take;

    // The new level is taken on the edge that completes the run, so the counter tops out at LAST.
    always_comb begin
        w_diff = (i_sync != r_level);
        w_take = w_diff && (r_cnt == LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (!w_diff) begin
            r_cnt   <= '0;
        end else if (w_take) begin
            r_level <= i_sync;
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;
    assign o_take  = w_take;
endmodule

module dip_debounce #(
    parameter int WIDTH         = 3,
    parameter int STABLE_CYCLES = 500_000
) (
    input  logic             i_clk,
    input  logic             i_res,
    input  logic [WIDTH-1:0] i_dip_raw,
    output logic [WIDTH-1:0] o_dip_out,
    output logic [WIDTH-1:0] o_dip_rise,
    output logic [WIDTH-1:0] o_dip_fall,
    output logic             o_changed
);
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_take;

    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_dip_raw;
            r_sync2 <= r_sync1;
        end
    end

    dip_debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_bit [WIDTH-1:0] (
        .i_clk   (i_clk),
        .i_res   (i_res),
        .i_sync  (r_sync2),
        .o_level (w_level),
        .o_take  (w_take)
    );

    // Direction comes from the level being left, so rise and fall are mutually exclusive.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
        end else begin
            r_rise    <= w_take & ~w_level;
            r_fall    <= w_take & w_level;
            r_changed <= |w_take;
        end
    end

    assign o_dip_out  = w_level;
    assign o_dip_rise = r_rise;
    assign o_dip_fall = r_fall;
    assign o_changed  = r_changed;
endmodule

// File: tb/tb_dip_debounce.sv
// Directed scenarios plus randomized switch activity checked against a sample-history model.
module tb_dip_debounce;
    localparam int W = 3;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         res;
    logic [W-1:0] raw;
    logic [W-1:0] dout, rise, fall;
    logic         chg;

    int checks   = 0;
    int failures = 0;

    // model: raw delayed two edges, then a level flips when the last S filter samples all differ
    logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall;
    logic         m_chg;
    logic [W-1:0] hist[$];

    dip_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .i_clk(clk), .i_res(res), .i_dip_raw(raw),
        .o_dip_out(dout), .o_dip_rise(rise), .o_dip_fall(fall), .o_changed(chg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic [W-1:0] d);
        logic [W-1:0] nr, nf;
        logic         all;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_out = '0;
            m_rise = '0; m_fall = '0; m_chg = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > S) void'(hist.pop_front());
            nr = '0; nf = '0;
            for (int i = 0; i < W; i++) begin
                all = (hist.size() == S);
                foreach (hist[k]) if (hist[k][i] == m_out[i]) all = 1'b0;
                if (all) begin
                    if (m_out[i]) nf[i] = 1'b1;
                    else          nr[i] = 1'b1;
                end
            end
            m_out  = m_out ^ (nr | nf);
            m_rise = nr;
            m_fall = nf;
            m_chg  = |(nr | nf);
            m_s2   = m_s1;
            m_s1   = d;
        end
    endtask

    task automatic cyc(input logic r, input logic [W-1:0] d);
        res = r;
        raw = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        check("dip_out",  32'(dout), 32'(m_out));
        check("dip_rise", 32'(rise), 32'(m_rise));
        check("dip_fall", 32'(fall), 32'(m_fall));
        check("changed",  32'(chg),  32'(m_chg));
        check("rise_and_fall", 32'(rise & fall), 32'd0);
    endtask

    // Hold d until changed strobes (bounded); n = number of edges taken
    task automatic hold_until_change(input logic [W-1:0] d, output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, d);
            if (chg) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n, nchg, pos, nfall;
        logic [W-1:0] v;
        int hold;
        res = 1'b1;
        raw = '0;
        m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;

        // 1. reset with all switches ON, then release
        for (int k = 0; k < 3; k++) cyc(1'b1, 3'b111);
        check("t1_rst_out", 32'(dout), 32'd0);
        check("t1_rst_chg", 32'(chg), 32'd0);
        hold_until_change(3'b111, n);
        check("t1_latency", n, 6);
        check("t1_out",  32'(dout), 32'h7);
        check("t1_rise", 32'(rise), 32'h7);
        cyc(1'b0, 3'b111);
        check("t1_one_cycle", 32'(chg), 32'd0);

        // 2. clean step on bit 1
        hold_until_change(3'b000, n);
        check("t2_clear_fall", 32'(fall), 32'h7);
        for (int k = 0; k < 3; k++) cyc(1'b0, 3'b000);
        hold_until_change(3'b010, n);
        check("t2_rise_lat", n, 6);
        check("t2_rise", 32'(rise), 32'h2);
        check("t2_out",  32'(dout), 32'h2);
        hold_until_change(3'b000, n);
        check("t2_fall_lat", n, 6);
        check("t2_fall", 32'(fall), 32'h2);
        for (int k = 0; k < 3; k++) cyc(1'b0, 3'b000);

        // 3. bounce on bit 0, then held high
        begin
            logic [8:0] seq;
            seq = 9'b111101101; // applied LSB first: 1,0,1,1,0,1,1,1,1
            nchg = 0; pos = 0; nfall = 0;
            for (int k = 0; k < 16; k++) begin
                cyc(1'b0, (k < 9) ? {2'b00, seq[k]} : 3'b001);
                if (chg) begin
                    nchg++;
                    pos = k + 1;
                    check("t3_rise", 32'(rise), 32'h1);
                end
                if (|fall) nfall++;
            end
            check("t3_nchg", nchg, 1);
            check("t3_pos", pos, 11);
            check("t3_nfall", nfall, 0);
        end

        // 4. 3-cycle glitch on bit 2
        nchg = 0;
        for (int k = 0; k < 12; k++) begin
            cyc(1'b0, (k < 3) ? 3'b101 : 3'b001);
            if (chg) nchg++;
        end
        check("t4_nchg", nchg, 0);
        check("t4_out", 32'(dout), 32'h1);

        // 5. simultaneous rise on bits 0 and 2
        hold_until_change(3'b000, n);
        for (int k = 0; k < 3; k++) cyc(1'b0, 3'b000);
        hold_until_change(3'b101, n);
        check("t5_lat", n, 6);
        check("t5_rise", 32'(rise), 32'h5);
        cyc(1'b0, 3'b101);
        check("t5_one_cycle", 32'(chg), 32'd0);

        // 6. reset while bit 0 is three samples into its run
        hold_until_change(3'b000, n);
        for (int k = 0; k < 3; k++) cyc(1'b0, 3'b000);
        nchg = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 3'b001);
            if (chg) nchg++;
        end
        cyc(1'b1, 3'b001);
        check("t6_no_early", nchg, 0);
        check("t6_rst_out", 32'(dout), 32'd0);
        hold_until_change(3'b001, n);
        check("t6_latency", n, 6);
        check("t6_rise", 32'(rise), 32'h1);

        // randomized activity with occasional resets
        v = '0;
        for (int k = 0; k < 60; k++) begin
            v = v ^ W'($urandom_range(0, 7));
            hold = $urandom_range(1, 8);
            for (int j = 0; j < hold; j++) begin
                if ($urandom_range(0, 3) == 0) cyc(1'b0, W'($urandom_range(0, 7)));
                else cyc(($urandom_range(0, 99) == 0), v);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
